// File: rtl/x_shift_pkg.sv
// Shared definitions for the execute-path shifters: widths, pipeline depth,
// the per-stage register record and the shifted-out-bits helper.
package x_shift_pkg;

    localparam int DATA_W    = 32;
    localparam int SHAMT_W   = 5;
    localparam int N_STAGES  = 5;
    // Tag field in the stage record is sized for the widest tag any client
    // uses; narrower tags are zero-extended on entry and truncated on exit.
    localparam int TAG_MAX_W = 16;

    typedef struct packed {
        logic                 valid;
        logic [DATA_W-1:0]    data;
        logic [SHAMT_W-1:0]   shamt;
        logic [TAG_MAX_W-1:0] tag;
        logic                 ovf;
    } stage_rec_t;

    // True when any of the top 'amt' bits of 'd' is set, i.e. a left shift
    // by 'amt' would push a 1 out of the MSB.
    function automatic logic shifted_out_any(input logic [DATA_W-1:0] d,
                                             input int                amt);
        return |(d >> (DATA_W - amt));
    endfunction

endpackage

// File: rtl/x_lshift_stage.sv
// One stage of the pipelined left shifter: conditionally shifts by 2^K and
// registers the whole operation record. Stage K consumes shift bit K.
// Build option LSHIFT_OVF_EN: accumulate the sticky shifted-out flag.
module x_lshift_stage
    import x_shift_pkg::*;
#(
    parameter int K = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    input  stage_rec_t rec_i,
    output stage_rec_t rec_o
);

    localparam int AMT = 1 << K;

    stage_rec_t rec_d;
    stage_rec_t rec_q;

    // Next-state record: apply this stage's power-of-two shift when its bit is set.
    always_comb begin
        rec_d = rec_i;
`ifndef LSHIFT_OVF_EN
        rec_d.ovf = 1'b0;
`endif
        if (rec_i.shamt[K]) begin
            rec_d.data = rec_i.data << AMT;
`ifdef LSHIFT_OVF_EN
            rec_d.ovf  = rec_i.ovf | shifted_out_any(rec_i.data, AMT);
`endif
        end else begin
            rec_d.data = rec_i.data;
        end
    end

    // Stage register: reset clears everything, flush kills only the valid
    // (and beats stall), stall freezes the record.
    always_ff @(posedge clock) begin
        if (reset) begin
            rec_q <= '0;
        end else if (flush) begin
            rec_q.valid <= 1'b0;
        end else if (stall) begin
            rec_q <= rec_q;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rec_o = rec_q;

endmodule

// File: rtl/x_lshift_pipe.sv
// Five-stage pipelined logical left shifter (sll) with a travelling
// destination tag. Outputs come straight from the last stage's registers.
// Build option LSHIFT_OVF_EN: enables the sticky 'ovf' output; without it
// 'ovf' is tied low. TAG_W must not exceed x_shift_pkg::TAG_MAX_W.
module x_lshift_pipe
    import x_shift_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in,
    input  logic [4:0]       shift,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [31:0]      out,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovf
);

    stage_rec_t entry_s;
    stage_rec_t stage_q_s [N_STAGES];
    stage_rec_t last_s;
    logic       unused_s;

    // Pack the incoming operation into a stage record for stage 0.
    always_comb begin
        entry_s                = '0;
        entry_s.valid          = in_valid;
        entry_s.data           = in;
        entry_s.shamt          = shift;
        entry_s.tag[TAG_W-1:0] = in_tag;
        entry_s.ovf            = 1'b0;
    end

    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            x_lshift_stage #(.K(gi)) u_stage (
                .clock (clock),
                .reset (reset),
                .stall (stall),
                .flush (flush),
                .rec_i (entry_s),
                .rec_o (stage_q_s[gi])
            );
        end else begin : g_rest
            x_lshift_stage #(.K(gi)) u_stage (
                .clock (clock),
                .reset (reset),
                .stall (stall),
                .flush (flush),
                .rec_i (stage_q_s[gi-1]),
                .rec_o (stage_q_s[gi])
            );
        end
    end

    assign last_s    = stage_q_s[N_STAGES-1];
    assign out_valid = last_s.valid;
    assign out       = last_s.data;
    assign out_tag   = last_s.tag[TAG_W-1:0];
`ifdef LSHIFT_OVF_EN
    assign ovf       = last_s.ovf;
`else
    assign ovf       = 1'b0;
`endif

    // Remaining shift bits are fully consumed by the last stage.
    assign unused_s  = ^{last_s.shamt, last_s.tag, last_s.ovf};

endmodule
